// File: rtl/taitosj_pkg.sv
// Shared constants for the object/playfield collision block: flag bit positions,
// CPU register addresses and the enable reset value.
package taitosj_pkg;

    localparam int F_OBJPF1 = 0;
    localparam int F_OBJPF2 = 1;
    localparam int F_OBJPF3 = 2;
    localparam int F_OBJOBJ = 3;
    localparam int F_PF1PF2 = 4;
    localparam int F_PF1PF3 = 5;
    localparam int F_PF2PF3 = 6;

    localparam logic [1:0] COLL_FLAGS = 2'd0;
    localparam logic [1:0] COLL_FX    = 2'd1;
    localparam logic [1:0] COLL_FY    = 2'd2;
    localparam logic [1:0] COLL_CNT   = 2'd3;

    localparam logic [6:0] COLL_EN_RST = 7'h7F;

    // Clamp an 8-bit count into the 7-bit field of the count register.
    function automatic logic [6:0] sat7(input logic [7:0] v);
        return (v > 8'd127) ? 7'h7F : v[6:0];
    endfunction

endpackage

// File: rtl/coll_event.sv
// Combinational overlap decoder: turns one pixel's object/playfield codes into
// the raw 7-bit collision event vector, already qualified by pix_ce and blanking.
module coll_event
    import taitosj_pkg::*;
(
    input  logic       pix_ce,
    input  logic       H_BLANK,
    input  logic       V_BLANK,
    input  logic [2:0] ob_code,
    input  logic       HITOB,
    input  logic [2:0] PF1,
    input  logic [2:0] PF2,
    input  logic [2:0] PF3,
    output logic [6:0] ev
);

    logic active;
    logic ob_opq, pf1_opq, pf2_opq, pf3_opq;

    always_comb begin
        ev      = '0;
        active  = pix_ce & ~H_BLANK & ~V_BLANK;
        ob_opq  = |ob_code;
        pf1_opq = |PF1;
        pf2_opq = |PF2;
        pf3_opq = |PF3;

        ev[F_OBJPF1] = active & ob_opq & pf1_opq;
        ev[F_OBJPF2] = active & ob_opq & pf2_opq;
        ev[F_OBJPF3] = active & ob_opq & pf3_opq;
        // Object/object is flagged when the line buffer was written, so H_BLANK is irrelevant.
        ev[F_OBJOBJ] = pix_ce & ~V_BLANK & ~HITOB;
        ev[F_PF1PF2] = active & pf1_opq & pf2_opq;
        ev[F_PF1PF3] = active & pf1_opq & pf3_opq;
        ev[F_PF2PF3] = active & pf2_opq & pf3_opq;
    end

endmodule

// File: rtl/obj_collision.sv
// Pixel-rate collision detector: sticky overlap flags, first object/playfield hit
// position, saturating hit count and a four-register CPU window.
module obj_collision
    import taitosj_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic       clkm_48MHZ,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       H_BLANK,
    input  logic       V_BLANK,
    input  logic [7:0] syncbus_HN,
    input  logic [7:0] syncbus_V,
    input  logic [3:0] OB,
    input  logic       HITOB,
    input  logic [2:0] PF1,
    input  logic [2:0] PF2,
    input  logic [2:0] PF3,
    input  logic [1:0] cpu_addr,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       COLL_IRQ
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [6:0]       flags;
    logic [6:0]       en;
    logic [7:0]       fx, fy;
    logic             first_valid;
    logic [CNT_W-1:0] cnt;
    logic             vb_q;

    logic [6:0] ev, ev_en, clr_mask;
    logic       objpf_hit, frame_start;
    logic [7:0] rd_data, cnt_ext;
    logic       ob_unused;

    assign ob_unused = OB[3];

    coll_event u_coll_event (
        .pix_ce  (pix_ce),
        .H_BLANK (H_BLANK),
        .V_BLANK (V_BLANK),
        .ob_code (OB[2:0]),
        .HITOB   (HITOB),
        .PF1     (PF1),
        .PF2     (PF2),
        .PF3     (PF3),
        .ev      (ev)
    );

    always_comb begin
        ev_en       = ev & en;
        objpf_hit   = |ev_en[F_OBJPF3:F_OBJPF1];
        frame_start = vb_q & ~V_BLANK;
        clr_mask    = (cpu_wr && cpu_addr == COLL_FLAGS) ? cpu_din[6:0] : 7'h00;
        cnt_ext     = 8'(cnt);
        case (cpu_addr)
            COLL_FLAGS: rd_data = {1'b0, flags};
            COLL_FX:    rd_data = fx;
            COLL_FY:    rd_data = fy;
            default:    rd_data = {first_valid, sat7(cnt_ext)};
        endcase
    end

    always_ff @(posedge clkm_48MHZ) begin
        if (reset) begin
            flags       <= '0;
            en          <= COLL_EN_RST;
            fx          <= '0;
            fy          <= '0;
            first_valid <= 1'b0;
            cnt         <= '0;
            vb_q        <= 1'b1;
            cpu_dout    <= '0;
            COLL_IRQ    <= 1'b0;
        end else begin
            vb_q  <= V_BLANK;
            // Clear is applied before the OR so a same-cycle event always survives.
            flags <= (flags & ~clr_mask) | ev_en;

            if (cpu_wr && cpu_addr == COLL_FX)
                en <= cpu_din[6:0];

            if (objpf_hit && (!first_valid || frame_start)) begin
                fx          <= syncbus_HN;
                fy          <= syncbus_V;
                first_valid <= 1'b1;
            end else if (frame_start) begin
                first_valid <= 1'b0;
            end

            if (frame_start)
                cnt <= objpf_hit ? CNT_W'(1) : '0;
            else if (objpf_hit && cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);

            if (cpu_rd)
                cpu_dout <= rd_data;

            COLL_IRQ <= |(flags & en);
        end
    end

endmodule

// File: tb/tb_obj_collision.sv
// Directed bench for obj_collision: vector table for single-pixel decode plus
// hand-written sequences for first-hit, enables, set-vs-clear, saturation and reset.
module tb_obj_collision;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_ce, H_BLANK, V_BLANK, HITOB;
    logic [7:0] syncbus_HN, syncbus_V;
    logic [3:0] OB;
    logic [2:0] PF1, PF2, PF3;
    logic [1:0] cpu_addr;
    logic       cpu_rd, cpu_wr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       COLL_IRQ;

    int errors = 0;
    int checks = 0;

    obj_collision #(.CNT_W(8)) dut (
        .clkm_48MHZ (clk),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .H_BLANK    (H_BLANK),
        .V_BLANK    (V_BLANK),
        .syncbus_HN (syncbus_HN),
        .syncbus_V  (syncbus_V),
        .OB         (OB),
        .HITOB      (HITOB),
        .PF1        (PF1),
        .PF2        (PF2),
        .PF3        (PF3),
        .cpu_addr   (cpu_addr),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .COLL_IRQ   (COLL_IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hb;
        logic       vb;
        logic [3:0] ob;
        logic       hitob;
        logic [2:0] pf1;
        logic [2:0] pf2;
        logic [2:0] pf3;
        logic [7:0] exp_f;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic pixel(input logic hb, input logic vb, input logic [3:0] ob, input logic hitob,
                         input logic [2:0] p1, input logic [2:0] p2, input logic [2:0] p3,
                         input logic [7:0] hn, input logic [7:0] v);
        H_BLANK = hb; V_BLANK = vb; OB = ob; HITOB = hitob;
        PF1 = p1; PF2 = p2; PF3 = p3; syncbus_HN = hn; syncbus_V = v;
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_din = d; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        cpu_addr = a; cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        d = cpu_dout;
    endtask

    task automatic frame_edge();
        V_BLANK = 1'b1;
        tick();
        V_BLANK = 1'b0;
        tick();
    endtask

    logic [7:0] rd;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'h1, 1'b1, 3'd0, 3'd3, 3'd0, 8'h02};
        vecs[1] = '{1'b1, 1'b0, 4'h1, 1'b1, 3'd0, 3'd3, 3'd0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h08};
        vecs[3] = '{1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 4'h8, 1'b1, 3'd1, 3'd0, 3'd0, 8'h00};
        vecs[5] = '{1'b0, 1'b0, 4'h2, 1'b1, 3'd1, 3'd0, 3'd5, 8'h25};
        vecs[6] = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd1, 3'd2, 3'd3, 8'h70};
        vecs[7] = '{1'b0, 1'b0, 4'h7, 1'b0, 3'd1, 3'd1, 3'd1, 8'h7F};
        vecs[8] = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd0, 3'd1, 3'd1, 8'h40};

        reset = 1'b1; pix_ce = 1'b0; H_BLANK = 1'b0; V_BLANK = 1'b1; HITOB = 1'b1;
        OB = '0; PF1 = '0; PF2 = '0; PF3 = '0; syncbus_HN = '0; syncbus_V = '0;
        cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_din = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_dout", cpu_dout, 8'h00);
        check("rst_irq", {7'h0, COLL_IRQ}, 8'h00);
        for (int a = 0; a < 4; a++) begin
            cpu_read(2'(a), rd);
            check($sformatf("rst_reg%0d", a), rd, 8'h00);
        end

        for (int i = 0; i < 9; i++) begin
            cpu_write(2'd0, 8'h7F);
            tick(); tick();
            pixel(vecs[i].hb, vecs[i].vb, vecs[i].ob, vecs[i].hitob,
                  vecs[i].pf1, vecs[i].pf2, vecs[i].pf3, 8'h10, 8'h20);
            if (i == 0) check("irq_not_yet", {7'h0, COLL_IRQ}, 8'h00);
            cpu_read(2'd0, rd);
            check($sformatf("vec%0d_flags", i), rd, vecs[i].exp_f);
            check($sformatf("vec%0d_irq", i), {7'h0, COLL_IRQ}, {7'h0, (vecs[i].exp_f != 8'h00)});
        end
        repeat (3) tick();
        check("dout_hold", cpu_dout, 8'h40);

        // First hit latch and frame-start clearing
        cpu_write(2'd0, 8'h7F);
        frame_edge();
        pixel(1'b0, 1'b0, 4'h1, 1'b1, 3'd1, 3'd0, 3'd0, 8'h40, 8'h22);
        pixel(1'b0, 1'b0, 4'h1, 1'b1, 3'd1, 3'd0, 3'd0, 8'h50, 8'h23);
        cpu_read(2'd1, rd); check("first_fx", rd, 8'h40);
        cpu_read(2'd2, rd); check("first_fy", rd, 8'h22);
        cpu_read(2'd3, rd); check("first_cnt", rd, 8'h82);
        frame_edge();
        cpu_read(2'd3, rd); check("frame_cnt", rd, 8'h00);
        cpu_read(2'd1, rd); check("frame_fx_kept", rd, 8'h40);
        cpu_read(2'd2, rd); check("frame_fy_kept", rd, 8'h22);

        // Enable mask
        cpu_write(2'd1, 8'h7E);
        cpu_write(2'd0, 8'h7F);
        tick(); tick();
        pixel(1'b0, 1'b0, 4'h1, 1'b1, 3'd1, 3'd0, 3'd0, 8'h00, 8'h30);
        tick();
        check("en_irq_off", {7'h0, COLL_IRQ}, 8'h00);
        cpu_read(2'd0, rd); check("en_masked", rd, 8'h00);
        pixel(1'b0, 1'b0, 4'h1, 1'b1, 3'd0, 3'd2, 3'd0, 8'h00, 8'h30);
        cpu_read(2'd0, rd); check("en_pf2", rd, 8'h02);

        // Clear and set in the same cycle
        cpu_write(2'd1, 8'h07);
        cpu_write(2'd0, 8'h7F);
        pixel(1'b0, 1'b0, 4'h1, 1'b1, 3'd1, 3'd1, 3'd1, 8'h00, 8'h31);
        cpu_read(2'd0, rd); check("setclr_pre", rd, 8'h07);
        H_BLANK = 1'b0; V_BLANK = 1'b0; OB = 4'h1; HITOB = 1'b1;
        PF1 = 3'd1; PF2 = 3'd0; PF3 = 3'd0; pix_ce = 1'b1;
        cpu_addr = 2'd0; cpu_din = 8'h01; cpu_wr = 1'b1;
        tick();
        pix_ce = 1'b0; cpu_wr = 1'b0;
        cpu_read(2'd0, rd); check("set_wins", rd, 8'h07);
        cpu_write(2'd0, 8'h07);
        cpu_read(2'd0, rd); check("clear_all", rd, 8'h00);

        // Counter saturation
        cpu_write(2'd1, 8'h7F);
        frame_edge();
        for (int n = 0; n < 100; n++)
            pixel(1'b0, 1'b0, 4'h1, 1'b1, 3'd1, 3'd0, 3'd0, 8'(n), 8'h40);
        cpu_read(2'd3, rd); check("cnt_100", rd, 8'hE4);
        for (int n = 0; n < 200; n++)
            pixel(1'b0, 1'b0, 4'h1, 1'b1, 3'd1, 3'd0, 3'd0, 8'(n), 8'h41);
        cpu_read(2'd3, rd); check("cnt_sat", rd, 8'hFF);

        // Reset mid-frame
        cpu_write(2'd1, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_dout", cpu_dout, 8'h00);
        check("mid_rst_irq", {7'h0, COLL_IRQ}, 8'h00);
        for (int a = 0; a < 4; a++) begin
            cpu_read(2'(a), rd);
            check($sformatf("mid_rst_reg%0d", a), rd, 8'h00);
        end
        pixel(1'b0, 1'b0, 4'h7, 1'b0, 3'd1, 3'd1, 3'd1, 8'h11, 8'h12);
        cpu_read(2'd0, rd); check("mid_rst_en", rd, 8'h7F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
